// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction classes and which source registers each class reads.
// Used by the decode/execute interlock logic.
package pipeline_pkg;

  localparam int REG_W = 5;

  typedef enum logic [2:0] {
    rrALU   = 3'd0,
    ALUimm  = 3'd1,
    load    = 3'd2,
    store   = 3'd3,
    branch  = 3'd4,
    ppMove  = 3'd5,
    ppHmove = 3'd6,
    ppVmove = 3'd7
  } instrType_t;

  // Every class reads RS, so this is constant today but keeps the table explicit.
  function automatic logic usesRS(instrType_t t);
    logic r;
    r = 1'b0;
    case (t)
      rrALU, ALUimm, load, store, branch, ppMove, ppHmove, ppVmove: r = 1'b1;
      default:                                                      r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic usesRT(instrType_t t);
    logic r;
    r = 1'b0;
    case (t)
      rrALU, store, branch, ppHmove, ppVmove: r = 1'b1;
      ALUimm, load, ppMove:                   r = 1'b0;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stall_unit.sv
// Load-use interlock: freezes PC and IF/ID and bubbles ID/EX when decode reads a register
// that the load in execute is about to write. Also tracks a stall flag and a saturating count.
module stall_unit
  import pipeline_pkg::*;
#(
  parameter int REG_W = pipeline_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       decInstrType,
  input  logic [2:0]       exInstrType,
  input  logic [REG_W-1:0] decRS,
  input  logic [REG_W-1:0] decRT,
  input  logic [REG_W-1:0] exRegDest,
  output logic             enPC,
  output logic             enIfId,
  output logic             rstIdEx,
  output logic             stallQ,
  output logic [CNT_W-1:0] stallCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  instrType_t decType;
  instrType_t exType;
  logic       rsHit;
  logic       rtHit;
  logic       hz;

  assign decType = instrType_t'(decInstrType);
  assign exType  = instrType_t'(exInstrType);

  // Register 0 is compared like any other index; a double match still yields a single hazard.
  always_comb begin
    rsHit = usesRS(decType) && (decRS == exRegDest);
    rtHit = usesRT(decType) && (decRT == exRegDest);
    hz    = (exType == load) && (rsHit || rtHit);
  end

  // Hazard steering is combinational and intentionally independent of reset.
  always_comb begin
    enPC    = 1'b1;
    enIfId  = 1'b1;
    rstIdEx = 1'b0;
    if (hz) begin
      enPC    = 1'b0;
      enIfId  = 1'b0;
      rstIdEx = 1'b1;
    end
  end

  // Performance state: counter holds at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallQ   <= 1'b0;
      stallCnt <= '0;
    end else begin
      stallQ <= hz;
      if (hz && (stallCnt != CNT_MAX)) begin
        stallCnt <= stallCnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_stall_unit.sv
// Self-checking bench for stall_unit: directed cases then random traffic against a
// table-driven model; a second instance with a 2-bit counter exercises saturation.
module tb_stall_unit;

  logic       clk;
  logic       rst;
  logic [2:0] decInstrType;
  logic [2:0] exInstrType;
  logic [4:0] decRS;
  logic [4:0] decRT;
  logic [4:0] exRegDest;

  logic        enPC, enIfId, rstIdEx, stallQ;
  logic [15:0] stallCnt;
  logic        enPC2, enIfId2, rstIdEx2, stallQ2;
  logic [1:0]  stallCnt2;

  int checks   = 0;
  int failures = 0;

  // Model state: hazard cycles since reset and last cycle's hazard.
  int modelCount = 0;
  bit modelQ     = 1'b0;

  // Classes that read RT: rrALU(0), store(3), branch(4), ppHmove(6), ppVmove(7).
  bit [7:0] readsRtMask = 8'b1101_1001;

  stall_unit #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .decInstrType(decInstrType), .exInstrType(exInstrType),
    .decRS(decRS), .decRT(decRT), .exRegDest(exRegDest),
    .enPC(enPC), .enIfId(enIfId), .rstIdEx(rstIdEx), .stallQ(stallQ), .stallCnt(stallCnt)
  );

  stall_unit #(.REG_W(5), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .decInstrType(decInstrType), .exInstrType(exInstrType),
    .decRS(decRS), .decRT(decRT), .exRegDest(exRegDest),
    .enPC(enPC2), .enIfId(enIfId2), .rstIdEx(rstIdEx2), .stallQ(stallQ2), .stallCnt(stallCnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit modelHazard();
    bit rsMatch;
    bit rtMatch;
    rsMatch = (decRS == exRegDest);
    rtMatch = readsRtMask[decInstrType] && (decRT == exRegDest);
    return (exInstrType == 3'd2) && (rsMatch || rtMatch);
  endfunction

  function automatic int satTo(int v, int maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkComb(input string tag);
    bit h;
    h = modelHazard();
    checkOutput({tag, ".enPC"},    {31'd0, enPC},    {31'd0, ~h});
    checkOutput({tag, ".enIfId"},  {31'd0, enIfId},  {31'd0, ~h});
    checkOutput({tag, ".rstIdEx"}, {31'd0, rstIdEx}, {31'd0, h});
    checkOutput({tag, ".rstIdEx2"}, {31'd0, rstIdEx2}, {31'd0, h});
  endtask

  task automatic checkSeq(input string tag);
    checkOutput({tag, ".stallQ"},    {31'd0, stallQ},  {31'd0, modelQ});
    checkOutput({tag, ".stallCnt"},  {16'd0, stallCnt}, 32'(satTo(modelCount, 65535)));
    checkOutput({tag, ".stallQ2"},   {31'd0, stallQ2}, {31'd0, modelQ});
    checkOutput({tag, ".stallCnt2"}, {30'd0, stallCnt2}, 32'(satTo(modelCount, 3)));
  endtask

  // Drive one cycle of inputs, check the combinational response, clock, then check state.
  task automatic applyStimulus(input string tag, input logic [2:0] dT, input logic [2:0] eT,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] dest, input logic r);
    bit h;
    decInstrType = dT;
    exInstrType  = eT;
    decRS        = rs;
    decRT        = rt;
    exRegDest    = dest;
    rst          = r;
    #1;
    checkComb(tag);
    h = modelHazard();
    @(posedge clk);
    if (r) begin
      modelCount = 0;
      modelQ     = 1'b0;
    end else begin
      modelQ = h;
      if (h) modelCount++;
    end
    #1;
    checkSeq(tag);
  endtask

  initial begin
    rst = 1'b1; decInstrType = 3'd0; exInstrType = 3'd0;
    decRS = '0; decRT = '0; exRegDest = '0;

    applyStimulus("reset", 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    checkOutput("reset.cntConst", {16'd0, stallCnt}, 32'd0);

    // Directed hazard/no-hazard cases on rrALU and ALUimm.
    applyStimulus("rr.both",   3'd0, 3'd2, 5'd1, 5'd1, 5'd1, 1'b0);
    checkOutput("rr.both.enPCConst", {31'd0, enPC}, 32'd0);
    applyStimulus("rr.rsOnly", 3'd0, 3'd2, 5'd1, 5'd2, 5'd1, 1'b0);
    applyStimulus("rr.rtOnly", 3'd0, 3'd2, 5'd2, 5'd1, 5'd1, 1'b0);
    checkOutput("rr.rtOnly.rstIdExConst", {31'd0, rstIdEx}, 32'd1);
    applyStimulus("rr.noMatch", 3'd0, 3'd2, 5'd1, 5'd1, 5'd2, 1'b0);
    checkOutput("rr.noMatch.enPCConst", {31'd0, enPC}, 32'd1);
    applyStimulus("imm.rtUnused", 3'd1, 3'd2, 5'd2, 5'd1, 5'd1, 1'b0);
    checkOutput("imm.rtUnused.enIfIdConst", {31'd0, enIfId}, 32'd1);
    applyStimulus("imm.rsHit", 3'd1, 3'd2, 5'd1, 5'd2, 5'd1, 1'b0);
    checkOutput("imm.rsHit.enIfIdConst", {31'd0, enIfId}, 32'd0);
    applyStimulus("reg0", 3'd0, 3'd2, 5'd0, 5'd5, 5'd0, 1'b0);

    // Non-load producers never stall, for every decode class.
    for (int e = 0; e < 8; e++) begin
      if (e == 2) continue;
      for (int d = 0; d < 8; d++) begin
        applyStimulus($sformatf("noLoad.e%0d.d%0d", e, d), 3'(d), 3'(e), 5'd3, 5'd3, 5'd3, 1'b0);
        checkOutput($sformatf("noLoad.e%0d.d%0d.enPCConst", e, d), {31'd0, enPC}, 32'd1);
      end
    end

    // Counter/flag sequence, also driving the 2-bit instance into saturation.
    applyStimulus("seq.rst", 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("seq.hold%0d", i), 3'd3, 3'd2, 5'd7, 5'd9, 5'd9, 1'b0);
    checkOutput("seq.cnt4", {16'd0, stallCnt}, 32'd4);
    checkOutput("seq.q1",   {31'd0, stallQ}, 32'd1);
    checkOutput("seq.sat3", {30'd0, stallCnt2}, 32'd3);
    applyStimulus("seq.idle", 3'd3, 3'd2, 5'd7, 5'd8, 5'd9, 1'b0);
    checkOutput("seq.idleCnt", {16'd0, stallCnt}, 32'd4);
    checkOutput("seq.idleQ",   {31'd0, stallQ}, 32'd0);
    applyStimulus("seq.midRst", 3'd3, 3'd2, 5'd9, 5'd9, 5'd9, 1'b1);
    checkOutput("seq.rstCnt", {16'd0, stallCnt}, 32'd0);
    checkOutput("seq.rstQ",   {31'd0, stallQ}, 32'd0);
    for (int i = 0; i < 6; i++)
      applyStimulus($sformatf("sat.hold%0d", i), 3'd0, 3'd2, 5'd4, 5'd4, 5'd4, 1'b0);
    checkOutput("sat.cnt2", {30'd0, stallCnt2}, 32'd3);
    checkOutput("sat.cnt16", {16'd0, stallCnt}, 32'd6);

    // Random traffic over a small register range so matches are frequent.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($sformatf("rnd%0d", i),
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
